fft8_input_loader: RTL
======================

FFT8_INPUT_LOADER -- requirements
Module: fft8_input_loader

Interface
REQ-001 Parameter N, default 8: FFT points; only 8 is supported.
REQ-002 Parameter WIDTH, default 12: bits per real/imag sample component.
REQ-003 Clock is clk; reset is rst, asynchronous, active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_ready  output  1  loader can accept a sample (combinational from state).
REQ-008 in_re / in_im  input  WIDTH each  signed sample, natural order.
REQ-009 in_last  input  1  marks final sample of a frame.
REQ-010 wr_en  output  1  register-file write strobe (registered).
REQ-011 wr_addr  output  3  register-file address (registered).
REQ-012 wr_re / wr_im  output  WIDTH each  write data (registered).
REQ-013 fft_start  output  1  one-cycle start pulse to FFT control FSM (registered).
REQ-014 fft_done  input  1  completion pulse from FFT control FSM.
REQ-015 busy  output  1  high from first accepted sample until fft_done is seen.
REQ-016 frame_err  output  1  one-cycle pulse on framing error (registered).

Function
REQ-017 States: LOAD, KICK, WAIT; state encoding is free.
REQ-018 in_ready=1 only in LOAD; 0 in KICK and WAIT.
REQ-019 Accept = in_valid & in_ready at a rising edge; the 3-bit sample counter cnt (0..7) increments per accept.
REQ-020 Cycle after each accept: wr_en=1, wr_addr=bitrev3(cnt at accept), wr_re/wr_im = accepted data; otherwise wr_en=0, and addr/data hold their last value.
REQ-021 bitrev3 map: 0->0, 1->4, 2->2, 3->6, 4->1, 5->5, 6->3, 7->7.
REQ-022 in_last accepted with cnt<7: frame_err pulses next cycle; cnt returns to 0; state stays LOAD; the already-written entries are overwritten by the next frame; no fft_start.
REQ-023 Accept with cnt==7 and in_last=0: frame_err pulses next cycle; the frame is still processed normally.
REQ-024 Accept with cnt==7: cnt wraps to 0; LOAD->KICK at that edge.
REQ-025 KICK lasts exactly one cycle, during which the final wr_en is high; fft_start=1 in the cycle after KICK, so start never precedes the last write; state moves to WAIT.
REQ-026 WAIT: fft_start=0 after its single cycle; fft_done sampled high -> LOAD, with in_ready=1 in the next cycle.
REQ-027 fft_done high while in LOAD or KICK is ignored.
REQ-028 in_valid while in_ready=0 is not accepted, and the upstream source must hold the sample.
REQ-029 busy=1 from the cycle after the first accept of a frame through the WAIT cycle in which fft_done is sampled; busy=0 in LOAD with cnt==0; a REQ-022 abort clears busy.
REQ-030 Throughput: one sample per cycle in LOAD; back-to-back frames are separated only by the KICK/WAIT period.

Reset
REQ-031 rst high: state=LOAD, cnt=0, wr_en=0, wr_addr=0, wr_re=0, wr_im=0, fft_start=0, busy=0, frame_err=0, all immediately and asynchronously.
REQ-032 rst mid-frame or during WAIT discards the partial or outstanding frame; no fft_start is issued for it.
REQ-033 First accept is possible at the first rising edge after rst deasserts.

Verification
REQ-034 Stream samples re=k, im=-k for k=0..7, in_valid held high, in_last on k=7 -> writes addr/re sequence 0/0, 4/1, 2/2, 6/3, 1/4, 5/5, 3/6, 7/7 on consecutive cycles; one fft_start pulse in the cycle after the addr-7 write; no frame_err.
REQ-035 After REQ-034, hold in_valid high with fft_done low for 20 cycles -> in_ready=0 and no wr_en; pulse fft_done -> in_ready=1 next cycle and busy=0.
REQ-036 in_last on the 3rd sample -> frame_err pulse one cycle later; no fft_start; the next full 8-sample frame behaves exactly as REQ-034.
REQ-037 8 samples with in_last=0 throughout -> frame_err pulse one cycle after the 8th accept; fft_start still issued.
REQ-038 Random in_valid gaps (~50% duty) -> same write sequence as REQ-034; wr_en count=8; exactly one fft_start.
REQ-039 Assert rst after the 5th accept -> all outputs go to reset values immediately; no fft_start; a subsequent clean frame passes REQ-034.

Source files
------------

// File: rtl/fft8_input_loader.sv
// fft8_input_loader
// Accepts a stream of complex samples in natural order and writes them into
// the FFT register file at bit-reversed addresses. Once the eighth sample has
// been written it fires a single start pulse to the FFT control FSM and then
// blocks new input until that FSM reports completion.
//
// The framing rule is that in_last must arrive together with the eighth
// sample of a frame.
// - in_last arriving early aborts the partial frame.
// - A missing in_last is flagged, but the frame is still processed.
// Both cases raise a one-cycle frame_err pulse.
module fft8_input_loader #(
    parameter int N     = 8,
    parameter int WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  logic                    in_last,
    output logic                    wr_en,
    output logic [2:0]              wr_addr,
    output logic signed [WIDTH-1:0] wr_re,
    output logic signed [WIDTH-1:0] wr_im,
    output logic                    fft_start,
    input  logic                    fft_done,
    output logic                    busy,
    output logic                    frame_err
);

    // Index of the final sample in a frame. The 3-bit counter and the
    // bit-reversal below only make sense for N == 8.
    localparam logic [2:0] LAST_IDX = 3'(N - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_KICK,
        S_WAIT
    } state_t;

    state_t state_reg, state_next;

    logic [2:0]              cnt_reg, cnt_next;
    logic                    wr_en_reg, wr_en_next;
    logic [2:0]              wr_addr_reg, wr_addr_next;
    logic signed [WIDTH-1:0] wr_re_reg, wr_re_next;
    logic signed [WIDTH-1:0] wr_im_reg, wr_im_next;
    logic                    fft_start_reg, fft_start_next;
    logic                    busy_reg, busy_next;
    logic                    frame_err_reg, frame_err_next;

    logic       accept;
    logic [2:0] cnt_rev;

    // Input is only taken while collecting a frame.
    assign in_ready = (state_reg == S_LOAD);
    assign accept   = in_valid & in_ready;

    // Bit-reversed write address: bit gi of the address is bit (2-gi) of the count.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_bitrev
            assign cnt_rev[gi] = cnt_reg[2 - gi];
        end
    endgenerate

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_re_next     = wr_re_reg;
        wr_im_next     = wr_im_reg;
        fft_start_next = 1'b0;
        busy_next      = busy_reg;
        frame_err_next = 1'b0;

        case (state_reg)
            S_LOAD: begin
                if (accept) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = cnt_rev;
                    wr_re_next   = in_re;
                    wr_im_next   = in_im;
                    busy_next    = 1'b1;
                    if (cnt_reg == LAST_IDX) begin
                        // Full frame. A missing in_last is reported, but the
                        // frame still goes to the FFT.
                        cnt_next       = 3'd0;
                        state_next     = S_KICK;
                        frame_err_next = ~in_last;
                    end else if (in_last) begin
                        // Short frame: drop it. The next frame overwrites the
                        // entries already written.
                        cnt_next       = 3'd0;
                        frame_err_next = 1'b1;
                        busy_next      = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end
            S_KICK: begin
                // The last write is on the bus during this cycle. Start goes
                // out one cycle later so that it never overtakes that write.
                state_next     = S_WAIT;
                fft_start_next = 1'b1;
            end
            S_WAIT: begin
                if (fft_done) begin
                    state_next = S_LOAD;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = S_LOAD;
                cnt_next   = 3'd0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sample counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= 3'd0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= 3'd0;
            wr_re_reg     <= '0;
            wr_im_reg     <= '0;
            fft_start_reg <= 1'b0;
            busy_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            wr_en_reg     <= wr_en_next;
            wr_addr_reg   <= wr_addr_next;
            wr_re_reg     <= wr_re_next;
            wr_im_reg     <= wr_im_next;
            fft_start_reg <= fft_start_next;
            busy_reg      <= busy_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign wr_en     = wr_en_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_re     = wr_re_reg;
    assign wr_im     = wr_im_reg;
    assign fft_start = fft_start_reg;
    assign busy      = busy_reg;
    assign frame_err = frame_err_reg;

endmodule
